// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - timing-state control unit driving the common-bus datapath
module bus_sequencer #(
    parameter bit INDIRECT_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ir,
    output logic [2:0]  select,
    output logic [5:0]  LD,
    output logic [4:0]  INR,
    output logic [4:0]  CLR,
    output logic        read,
    output logic        write,
    output logic        enable,
    output logic [1:0]  alu_op,
    output logic [2:0]  sc,
    output logic        running,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t     state, next_state;
    logic [2:0] opcode;
    logic       ibit;
    logic       cla, inc, hlt;
    logic       mem_ref;
    logic       reg_ref;

    // Address field and remaining register-reference bits are consumed by the datapath.
    logic unused_ir;
    assign unused_ir = ^{ir[10:6], ir[4:1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            opcode <= 3'd0;
            ibit   <= 1'b0;
            cla    <= 1'b0;
            inc    <= 1'b0;
            hlt    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_T2) begin
                opcode <= ir[14:12];
                ibit   <= ir[15];
                cla    <= ir[11];
                inc    <= ir[5];
                hlt    <= ir[0];
            end
        end
    end

    assign mem_ref = (opcode <= 3'd4);
    assign reg_ref = (opcode == 3'd7) && !ibit;

    always_comb begin
        next_state = state;
        select     = 3'b000;
        LD         = 6'b0;
        INR        = 5'b0;
        CLR        = 5'b0;
        read       = 1'b0;
        write      = 1'b0;
        alu_op     = 2'b00;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) next_state = S_T0;
            end
            S_T0: begin
                select     = 3'b010;
                LD[0]      = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                select     = 3'b111;
                read       = 1'b1;
                LD[4]      = 1'b1;
                INR[1]     = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                select     = 3'b101;
                LD[0]      = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                if (mem_ref) begin
                    if (ibit && INDIRECT_EN) begin
                        select = 3'b111;
                        read   = 1'b1;
                        LD[0]  = 1'b1;
                    end
                    next_state = S_T4;
                end else if (reg_ref) begin
                    // CLA wins over INC when both are encoded.
                    if (cla)      CLR[3] = 1'b1;
                    else if (inc) INR[3] = 1'b1;
                    next_state = hlt ? S_HALT : S_T0;
                end else begin
                    next_state = S_T0;
                end
            end
            S_T4: begin
                case (opcode)
                    3'd0, 3'd1, 3'd2: begin
                        select     = 3'b111;
                        read       = 1'b1;
                        LD[2]      = 1'b1;
                        next_state = S_T5;
                    end
                    3'd3: begin
                        select     = 3'b100;
                        write      = 1'b1;
                        next_state = S_T0;
                    end
                    default: begin
                        select     = 3'b001;
                        LD[1]      = 1'b1;
                        next_state = S_T0;
                    end
                endcase
            end
            S_T5: begin
                LD[3]      = 1'b1;
                alu_op     = opcode[1:0];
                next_state = S_T0;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        sc = 3'd0;
        if (state != S_IDLE && state != S_HALT) sc = state - 3'd1;
    end

    assign enable  = (select != 3'b000);
    assign running = (state != S_IDLE) && (state != S_HALT);
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - randomized instruction-level check of bus_sequencer against a microprogram model
module tb_bus_sequencer;

    typedef struct packed {
        logic [2:0] sc;
        logic [2:0] sel;
        logic [5:0] ld;
        logic [4:0] inr;
        logic [4:0] clr;
        logic       rd;
        logic       wr;
        logic [1:0] alu;
        logic       run;
        logic       hlt;
    } ctl_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ir    = 16'h0;

    logic [2:0] sel_a, sel_b, sc_a, sc_b;
    logic [5:0] ld_a, ld_b;
    logic [4:0] inr_a, inr_b, clr_a, clr_b;
    logic       rd_a, rd_b, wr_a, wr_b, en_a, en_b, run_a, run_b, hlt_a, hlt_b;
    logic [1:0] alu_a, alu_b;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clock = ~clock;

    bus_sequencer #(.INDIRECT_EN(1'b1)) u_ind (
        .clock(clock), .reset(reset), .start(start), .ir(ir),
        .select(sel_a), .LD(ld_a), .INR(inr_a), .CLR(clr_a), .read(rd_a), .write(wr_a),
        .enable(en_a), .alu_op(alu_a), .sc(sc_a), .running(run_a), .halted(hlt_a)
    );

    bus_sequencer #(.INDIRECT_EN(1'b0)) u_dir (
        .clock(clock), .reset(reset), .start(start), .ir(ir),
        .select(sel_b), .LD(ld_b), .INR(inr_b), .CLR(clr_b), .read(rd_b), .write(wr_b),
        .enable(en_b), .alu_op(alu_b), .sc(sc_b), .running(run_b), .halted(hlt_b)
    );

    ctl_t obs_a, obs_b;
    assign obs_a = {sc_a, sel_a, ld_a, inr_a, clr_a, rd_a, wr_a, alu_a, run_a, hlt_a};
    assign obs_b = {sc_b, sel_b, ld_b, inr_b, clr_b, rd_b, wr_b, alu_b, run_b, hlt_b};

    localparam ctl_t IDLE_C = '0;
    localparam ctl_t HALT_C = 28'h1;

    // Instruction length in cycles from T0 entry, by instruction class.
    function automatic int instr_len(input logic [15:0] w);
        if (w[14:12] <= 3'd2) return 6;
        if (w[14:12] <= 3'd4) return 5;
        return 4;
    endfunction

    function automatic bit is_hlt(input logic [15:0] w);
        return (w[14:12] == 3'd7) && !w[15] && w[0];
    endfunction

    // Register transfers of step t of instruction w, expressed as bus controls.
    function automatic ctl_t micro(input logic [15:0] w, input bit ind_en, input int t);
        ctl_t c = '0;
        logic [2:0] op = w[14:12];
        c.sc  = 3'(t);
        c.run = 1'b1;
        case (t)
            0: begin c.sel = 3'd2; c.ld = 6'b000001; end
            1: begin c.sel = 3'd7; c.rd = 1'b1; c.ld = 6'b010000; c.inr = 5'b00010; end
            2: begin c.sel = 3'd5; c.ld = 6'b000001; end
            3: begin
                if (op <= 3'd4 && w[15] && ind_en) begin
                    c.sel = 3'd7; c.rd = 1'b1; c.ld = 6'b000001;
                end else if (op == 3'd7 && !w[15]) begin
                    if (w[11])     c.clr = 5'b01000;
                    else if (w[5]) c.inr = 5'b01000;
                end
            end
            4: begin
                if (op <= 3'd2) begin c.sel = 3'd7; c.rd = 1'b1; c.ld = 6'b000100; end
                else if (op == 3'd3) begin c.sel = 3'd4; c.wr = 1'b1; end
                else begin c.sel = 3'd1; c.ld = 6'b000010; end
            end
            default: begin
                c.ld = 6'b001000;
                case (op)
                    3'd0:    c.alu = 2'b00;
                    3'd1:    c.alu = 2'b01;
                    default: c.alu = 2'b10;
                endcase
            end
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input ctl_t ea, input ctl_t eb);
        n_asserts++;
        assert (obs_a === ea) else begin
            n_fails++;
            $error("FAIL %s ind: observed=%h expected=%h", tag, obs_a, ea);
        end
        n_asserts++;
        assert (obs_b === eb) else begin
            n_fails++;
            $error("FAIL %s dir: observed=%h expected=%h", tag, obs_b, eb);
        end
        n_asserts++;
        assert (en_a === (ea.sel != 3'd0)) else begin
            n_fails++;
            $error("FAIL %s enable_ind: observed=%b expected=%b", tag, en_a, ea.sel != 3'd0);
        end
        n_asserts++;
        assert (en_b === (eb.sel != 3'd0)) else begin
            n_fails++;
            $error("FAIL %s enable_dir: observed=%b expected=%b", tag, en_b, eb.sel != 3'd0);
        end
    endtask

    // Called at the falling edge of T0; returns at the falling edge of the next T0.
    task automatic exec(input logic [15:0] w, input string tag);
        ir = w;
        for (int t = 0; t < instr_len(w); t++) begin
            chk($sformatf("%s_t%0d", tag, t), micro(w, 1'b1, t), micro(w, 1'b0, t));
            start = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        start = 1'b0;
        if (is_hlt(w)) begin
            chk({tag, "_halt"}, HALT_C, HALT_C);
            @(negedge clock);
            chk({tag, "_halt_hold"}, HALT_C, HALT_C);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset", IDLE_C, IDLE_C);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_after_release", IDLE_C, IDLE_C);
        @(negedge clock);
        chk("idle_no_start", IDLE_C, IDLE_C);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        exec(16'h2123, "lda");
        exec(16'h9050, "add_ind");
        exec(16'h3010, "sta");
        exec(16'h4020, "bun");
        exec(16'h7820, "cla_inc");
        exec(16'h7001, "hlt");
        exec(16'h8000, "and_ind");
        exec(16'hF040, "rr_ibit");
        exec(16'h5123, "nop5");
        for (int k = 0; k < 60; k++) begin
            exec(16'($urandom), $sformatf("rnd%0d", k));
        end

        ir = 16'h2123;
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("pre_rst_t%0d", t), micro(16'h2123, 1'b1, t), micro(16'h2123, 1'b0, t));
            @(negedge clock);
        end
        chk("pre_rst_t4", micro(16'h2123, 1'b1, 4), micro(16'h2123, 1'b0, 4));
        #1 reset = 1'b1;
        #1 chk("rst_async", IDLE_C, IDLE_C);
        @(negedge clock);
        chk("rst_held", IDLE_C, IDLE_C);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_released", IDLE_C, IDLE_C);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exec(16'h1abc, "add_after_rst");
        chk("t0_after_rst", micro(16'h0, 1'b1, 0), micro(16'h0, 1'b0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
